slot_tracker: RTL and testbench
===============================

Name: slot_tracker

Overview:
- Parametrised successor to the fixed 16-slot transaction bookkeeping: a circular table of outstanding AXI write transactions, each slot holding {id, tran_type, done}.
- Allocates a slot per accepted AW, flags same-ID hazards (REGULAR vs BLOCK), marks slots done on B completion by index, and retires slots strictly in allocation order.
- Sits between the AW FIFO and the speculative buffer logic in top.

Parameters:
- SLOT_AMOUNT, 16, number of tracked slots; power of 2, at least 2.
- ID_W, 4, transaction ID width.
- TYPE_W, 2, tran_type width; encodings REGULAR=00, BLOCK=01, DIVERT=10, UNLUCKY=11.
- IDX_W, $clog2(SLOT_AMOUNT), slot index width (derived localparam).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_valid  in  1  allocation request.
- alloc_ready  out  1  table not full.
- alloc_id  in  ID_W  transaction ID.
- alloc_type  in  TYPE_W  requested type (REGULAR or DIVERT).
- alloc_index  out  IDX_W  slot granted (= tail); valid while alloc_ready.
- alloc_state  out  TYPE_W  resulting state of the allocation (combinational).
- done_valid  in  1  completion strobe.
- done_index  in  IDX_W  slot to mark done.
- done_err  out  1  one-cycle pulse: done on an invalid or already-done slot.
- ret_valid  out  1  head slot valid and done.
- ret_ready  in  1  consumer accepts retirement.
- ret_id  out  ID_W  head slot ID.
- ret_type  out  TYPE_W  head slot stored state.
- count  out  IDX_W+1  occupied slots.
- empty  out  1  count == 0.
- full  out  1  count == SLOT_AMOUNT.

Behaviour:
- Storage per slot: valid, done, id, tran_type. head and tail are IDX_W-bit pointers that wrap naturally modulo SLOT_AMOUNT. count is held in a register.
- Reset: all valid/done = 0; head = tail = count = 0. Outputs: alloc_ready = 1, alloc_index = 0, ret_valid = 0, done_err = 0, empty = 1, full = 0.
- Allocation fires when alloc_valid && alloc_ready.
  - Next edge: slot[tail] gets {valid=1, done=0, id, tran_type=alloc_state}; tail increments.
- alloc_state rules:
  - If any valid && !done slot has id == alloc_id, alloc_state = BLOCK, regardless of alloc_type.
  - Otherwise alloc_state = alloc_type. An alloc_type of BLOCK or UNLUCKY is passed through unchanged.
  - The hazard compare uses registered state only; an allocation in the same cycle does not see itself.
- alloc_ready = !full, taken from registered count. There is no bypass: when full, a simultaneous retire does not enable alloc until the next cycle.
- Completion: when done_valid is high, and slot[done_index] is valid && !done, done is set at the next edge.
  - Otherwise the strobe is ignored and done_err pulses high on the next cycle.
- Retirement:
  - ret_valid = slot[head].valid && slot[head].done.
  - On ret_valid && ret_ready: slot[head].valid and slot[head].done clear; head increments.
  - Out-of-order completions wait until the older slots ahead of them retire.
- Simultaneous events:
  - Alloc + retire in one cycle: count unchanged; both pointers advance.
  - Done on the head slot in the same cycle as a retire is impossible, because ret_valid requires done already set.
  - A done strobe for the slot being allocated this cycle is an error (slot not yet valid).
- ret_id and ret_type are driven from slot[head] combinationally. Their values are don't-care when ret_valid is 0.
- Reset asserted mid-operation discards all slots in one cycle. Outputs return to their reset values on the next edge.

Optional Feature:
- Macro SLOT_TRACKER_STATS_EN.
- Defined:
  - Adds outputs hwm (IDX_W+1), the peak count since reset, and block_cnt (16 bits, saturating), the number of allocations that resolved to BLOCK.
  - Both cleared by rst.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then allocate id=3 REGULAR: alloc_index=0, alloc_state=REGULAR, count=1. Allocate id=3 REGULAR again: alloc_state=BLOCK, index=1.
- Fill 16 slots with ids 0..15: full=1, alloc_ready=0. Then alloc_valid=1 with done on slot 0 and ret_ready=1: retire occurs first, alloc_ready returns 1 one cycle later, next alloc_index=0 (wrap).
- Allocate slots 0,1,2 and mark done 2 then 1: ret_valid stays 0. Mark done 0: ret_valid=1, and with ret_ready=1 held, ids retire in order 0,1,2 on consecutive cycles.
- done_valid with done_index=5 on an empty table: done_err=1 for one cycle, state unchanged. Repeat done on an already-done slot: done_err=1.
- Allocate 6 slots, assert rst for one cycle mid-burst: count=0, empty=1, ret_valid=0. Next alloc gets index 0.
- With SLOT_TRACKER_STATS_EN: allocate 5, retire 5, allocate 2 (one with a duplicate id): hwm=5, block_cnt=1.

Source files
------------

// File: rtl/slot_tracker_if.sv
// Allocation / completion / retirement bundle for slot_tracker.
// The master side is the AW/B front end and retirement consumer; slave is the tracker.
interface slot_tracker_if #(
    parameter int SLOT_AMOUNT = 16,
    parameter int ID_W        = 4,
    parameter int TYPE_W      = 2
);
    localparam int IDX_W = $clog2(SLOT_AMOUNT);

    logic              alloc_valid;
    logic              alloc_ready;
    logic [ID_W-1:0]   alloc_id;
    logic [TYPE_W-1:0] alloc_type;
    logic [IDX_W-1:0]  alloc_index;
    logic [TYPE_W-1:0] alloc_state;
    logic              done_valid;
    logic [IDX_W-1:0]  done_index;
    logic              done_err;
    logic              ret_valid;
    logic              ret_ready;
    logic [ID_W-1:0]   ret_id;
    logic [TYPE_W-1:0] ret_type;
    logic [IDX_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output alloc_valid, alloc_id, alloc_type, done_valid, done_index, ret_ready,
        input  alloc_ready, alloc_index, alloc_state, done_err, ret_valid, ret_id,
               ret_type, count, empty, full
    );

    modport slave (
        input  alloc_valid, alloc_id, alloc_type, done_valid, done_index, ret_ready,
        output alloc_ready, alloc_index, alloc_state, done_err, ret_valid, ret_id,
               ret_type, count, empty, full
    );
endinterface

// File: rtl/slot_tracker.sv
// Circular table of outstanding AXI write transactions: allocate at tail, mark done by index,
// retire in order from head. Optional statistics (hwm, block_cnt) under SLOT_TRACKER_STATS_EN.
module slot_tracker #(
    parameter  int SLOT_AMOUNT = 16,
    parameter  int ID_W        = 4,
    parameter  int TYPE_W      = 2,
    localparam int IDX_W       = $clog2(SLOT_AMOUNT)
) (
    input  logic           clk,
    input  logic           rst,
`ifdef SLOT_TRACKER_STATS_EN
    output logic [IDX_W:0] hwm,
    output logic [15:0]    block_cnt,
`endif
    slot_tracker_if.slave  bus
);
    localparam logic [TYPE_W-1:0] TYPE_BLOCK = TYPE_W'(1);

    logic [SLOT_AMOUNT-1:0] r_valid;
    logic [SLOT_AMOUNT-1:0] r_done;
    logic [ID_W-1:0]        r_id   [SLOT_AMOUNT];
    logic [TYPE_W-1:0]      r_type [SLOT_AMOUNT];
    logic [IDX_W-1:0]       r_head;
    logic [IDX_W-1:0]       r_tail;
    logic [IDX_W:0]         r_count;
    logic                   r_done_err;

    logic                   w_hazard;
    logic [TYPE_W-1:0]      w_alloc_state;
    logic                   w_full;
    logic                   w_alloc_fire;
    logic                   w_ret_valid;
    logic                   w_ret_fire;
    logic                   w_done_ok;
    logic [IDX_W:0]         w_count_next;

    // Same-ID hazard looks only at registered slots, so this cycle's allocation never matches itself.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < SLOT_AMOUNT; i++) begin
            if (r_valid[i] && !r_done[i] && (r_id[i] == bus.alloc_id)) w_hazard = 1'b1;
        end
        w_alloc_state = w_hazard ? TYPE_BLOCK : bus.alloc_type;
    end

    assign w_full       = (r_count == (IDX_W+1)'(SLOT_AMOUNT));
    assign w_alloc_fire = bus.alloc_valid && !w_full;
    assign w_ret_valid  = r_valid[r_head] && r_done[r_head];
    assign w_ret_fire   = w_ret_valid && bus.ret_ready;
    assign w_done_ok    = r_valid[bus.done_index] && !r_done[bus.done_index];
    assign w_count_next = r_count + (IDX_W+1)'(w_alloc_fire) - (IDX_W+1)'(w_ret_fire);

    // Control state; later assignments win, but alloc/done/retire never target the same slot bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_done     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_done_err <= 1'b0;
        end else begin
            r_done_err <= bus.done_valid && !w_done_ok;
            if (bus.done_valid && w_done_ok) r_done[bus.done_index] <= 1'b1;
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + IDX_W'(1);
            end
            if (w_ret_fire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + IDX_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // NOTE: payload storage has no reset; its contents are qualified by r_valid everywhere.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_id[r_tail]   <= bus.alloc_id;
            r_type[r_tail] <= w_alloc_state;
        end
    end

`ifdef SLOT_TRACKER_STATS_EN
    logic [IDX_W:0] r_hwm;
    logic [15:0]    r_block_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hwm       <= '0;
            r_block_cnt <= '0;
        end else begin
            if (w_count_next > r_hwm) r_hwm <= w_count_next;
            if (w_alloc_fire && (w_alloc_state == TYPE_BLOCK) && (r_block_cnt != 16'hFFFF))
                r_block_cnt <= r_block_cnt + 16'd1;
        end
    end

    assign hwm       = r_hwm;
    assign block_cnt = r_block_cnt;
`endif

    assign bus.alloc_ready = !w_full;
    assign bus.alloc_index = r_tail;
    assign bus.alloc_state = w_alloc_state;
    assign bus.done_err    = r_done_err;
    assign bus.ret_valid   = w_ret_valid;
    assign bus.ret_id      = r_id[r_head];
    assign bus.ret_type    = r_type[r_head];
    assign bus.count       = r_count;
    assign bus.empty       = (r_count == '0);
    assign bus.full        = w_full;
endmodule

// File: tb/tb_slot_tracker.sv
// Directed self-checking bench for slot_tracker (16 slots, 4-bit IDs).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_slot_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef SLOT_TRACKER_STATS_EN
    logic [4:0]  hwm;
    logic [15:0] block_cnt;
`endif

    slot_tracker_if #(.SLOT_AMOUNT(16), .ID_W(4), .TYPE_W(2)) bus ();

    slot_tracker #(.SLOT_AMOUNT(16), .ID_W(4), .TYPE_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef SLOT_TRACKER_STATS_EN
        .hwm       (hwm),
        .block_cnt (block_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid = 1'b0;
        bus.alloc_id    = '0;
        bus.alloc_type  = '0;
        bus.done_valid  = 1'b0;
        bus.done_index  = '0;
        bus.ret_ready   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] id, input logic [1:0] typ);
        bus.alloc_valid = 1'b1;
        bus.alloc_id    = id;
        bus.alloc_type  = typ;
        tick();
        bus.alloc_valid = 1'b0;
    endtask

    task automatic mark_done(input logic [3:0] idx);
        bus.done_valid = 1'b1;
        bus.done_index = idx;
        tick();
        bus.done_valid = 1'b0;
    endtask

    initial begin
        idle();
        tick();
        do_reset();

        // Reset values
        check("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        check("rst_alloc_index", 32'(bus.alloc_index), 32'd0);
        check("rst_ret_valid",   32'(bus.ret_valid),   32'd0);
        check("rst_done_err",    32'(bus.done_err),    32'd0);
        check("rst_empty",       32'(bus.empty),       32'd1);
        check("rst_full",        32'(bus.full),        32'd0);
        check("rst_count",       32'(bus.count),       32'd0);

        // Hazard detection and type pass-through
        bus.alloc_valid = 1'b1; bus.alloc_id = 4'd3; bus.alloc_type = 2'b00;
        #1;
        check("a0_state", 32'(bus.alloc_state), 32'd0);
        check("a0_index", 32'(bus.alloc_index), 32'd0);
        tick();
        check("a0_count", 32'(bus.count), 32'd1);
        #1;
        check("a1_state_block", 32'(bus.alloc_state), 32'd1);
        check("a1_index",       32'(bus.alloc_index), 32'd1);
        tick();
        bus.alloc_id = 4'd7; bus.alloc_type = 2'b10;
        #1;
        check("a2_state_divert", 32'(bus.alloc_state), 32'd2);
        bus.alloc_id = 4'd8; bus.alloc_type = 2'b11;
        #1;
        check("a2_state_unlucky", 32'(bus.alloc_state), 32'd3);
        bus.alloc_valid = 1'b0;
        check("a_count2", 32'(bus.count), 32'd2);

        // Fill all 16 slots, then retire-before-alloc when full
        do_reset();
        for (int i = 0; i < 16; i++) alloc(4'(i), 2'b00);
        check("fill_full",        32'(bus.full),        32'd1);
        check("fill_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        check("fill_count",       32'(bus.count),       32'd16);
        bus.alloc_valid = 1'b1; bus.alloc_id = 4'd0; bus.alloc_type = 2'b00;
        bus.done_valid  = 1'b1; bus.done_index = 4'd0;
        bus.ret_ready   = 1'b1;
        tick();
        bus.done_valid = 1'b0;
        check("full_ret_valid",   32'(bus.ret_valid),   32'd1);
        check("full_ret_id",      32'(bus.ret_id),      32'd0);
        check("full_still_block", 32'(bus.alloc_ready), 32'd0);
        check("full_count16",     32'(bus.count),       32'd16);
        tick();
        bus.ret_ready = 1'b0;
        check("wrap_count",       32'(bus.count),       32'd15);
        check("wrap_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        check("wrap_index",       32'(bus.alloc_index), 32'd0);
        check("wrap_state",       32'(bus.alloc_state), 32'd0);
        tick();
        bus.alloc_valid = 1'b0;
        check("wrap_refull", 32'(bus.full), 32'd1);

        // Out-of-order completion, in-order retirement
        do_reset();
        alloc(4'd0, 2'b00);
        alloc(4'd1, 2'b00);
        alloc(4'd2, 2'b00);
        mark_done(4'd2);
        mark_done(4'd1);
        check("ooo_wait", 32'(bus.ret_valid), 32'd0);
        mark_done(4'd0);
        check("ooo_ret_valid0", 32'(bus.ret_valid), 32'd1);
        check("ooo_ret_id0",    32'(bus.ret_id),    32'd0);
        check("ooo_ret_type0",  32'(bus.ret_type),  32'd0);
        bus.ret_ready = 1'b1;
        tick();
        check("ooo_ret_valid1", 32'(bus.ret_valid), 32'd1);
        check("ooo_ret_id1",    32'(bus.ret_id),    32'd1);
        tick();
        check("ooo_ret_valid2", 32'(bus.ret_valid), 32'd1);
        check("ooo_ret_id2",    32'(bus.ret_id),    32'd2);
        tick();
        bus.ret_ready = 1'b0;
        check("ooo_drained", 32'(bus.ret_valid), 32'd0);
        check("ooo_empty",   32'(bus.empty),     32'd1);

        // Completion errors: invalid slot, then an already-done slot
        mark_done(4'd5);
        check("err_invalid",       32'(bus.done_err), 32'd1);
        check("err_invalid_count", 32'(bus.count),    32'd0);
        check("err_invalid_rv",    32'(bus.ret_valid), 32'd0);
        tick();
        check("err_pulse_end", 32'(bus.done_err), 32'd0);
        check("err_alloc_idx", 32'(bus.alloc_index), 32'd3);
        alloc(4'd4, 2'b00);
        mark_done(4'd3);
        check("err_good_done", 32'(bus.done_err), 32'd0);
        mark_done(4'd3);
        check("err_redone", 32'(bus.done_err), 32'd1);
        tick();
        check("err_redone_end", 32'(bus.done_err), 32'd0);

        // Mid-burst reset
        do_reset();
        for (int i = 0; i < 6; i++) alloc(4'(i), 2'b00);
        check("burst_count6", 32'(bus.count), 32'd6);
        bus.alloc_valid = 1'b1; bus.alloc_id = 4'd6;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.alloc_valid = 1'b0;
        check("mid_rst_count",     32'(bus.count),       32'd0);
        check("mid_rst_empty",     32'(bus.empty),       32'd1);
        check("mid_rst_ret_valid", 32'(bus.ret_valid),   32'd0);
        check("mid_rst_index",     32'(bus.alloc_index), 32'd0);
        bus.alloc_valid = 1'b1; bus.alloc_id = 4'd5; bus.alloc_type = 2'b00;
        #1;
        check("mid_rst_no_hazard", 32'(bus.alloc_state), 32'd0);
        tick();
        bus.alloc_valid = 1'b0;
        check("mid_rst_count1", 32'(bus.count), 32'd1);

`ifdef SLOT_TRACKER_STATS_EN
        // Statistics: peak occupancy and BLOCK resolution count
        do_reset();
        check("stats_rst_hwm", 32'(hwm),       32'd0);
        check("stats_rst_blk", 32'(block_cnt), 32'd0);
        for (int i = 0; i < 5; i++) alloc(4'(i), 2'b00);
        for (int i = 0; i < 5; i++) mark_done(4'(i));
        bus.ret_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.ret_ready = 1'b0;
        alloc(4'd7, 2'b00);
        alloc(4'd7, 2'b00);
        check("stats_hwm",       32'(hwm),       32'd5);
        check("stats_block_cnt", 32'(block_cnt), 32'd1);
        check("stats_count",     32'(bus.count), 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
